// File: rtl/pc_pkg.sv
// Shared types and constants for the SAP-2 program counter and its return stack.
// Latency: n/a (package only: op enum, strobe-priority resolver, default sizes).
// Backpressure: none; consumers are single-cycle control-path blocks.
package pc_pkg;

    // Default geometry used when the instantiating level does not override it.
    localparam int unsigned PC_ADDR_WIDTH_DEF  = 16;
    localparam int unsigned PC_STACK_DEPTH_DEF = 4;

    // One operation per cycle, selected from the microcode strobes.
    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_LOAD = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_e;

    // Strobe priority: load > call > ret > enable > hold. Lower-priority
    // strobes asserted alongside a higher one are simply dropped.
    function automatic pc_op_e pc_resolve_op(
        input logic load,
        input logic call,
        input logic ret,
        input logic enable
    );
        pc_op_e op;
        if (load) begin
            op = PC_LOAD;
        end else if (call) begin
            op = PC_CALL;
        end else if (ret) begin
            op = PC_RET;
        end else if (enable) begin
            op = PC_INC;
        end else begin
            op = PC_HOLD;
        end
        return op;
    endfunction

    // Depth pointer must be able to express 0..depth inclusive.
    function automatic int unsigned pc_ptr_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses: push writes above the top, pop exposes the entry below.
// Latency: 1 cycle (depth and top update on the clock edge after push/pop).
// Backpressure: push while full and pop while empty are ignored; caller flags errors.
//
// Ports:
//   clk, reset_n       clock, async active-low reset (clears depth only)
//   push, push_data    write push_data as the new top entry
//   pop                discard the top entry
//   top                current top entry (don't-care when empty)
//   full, empty        decoded from the registered depth pointer
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PC_ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = PC_STACK_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = pc_ptr_width(DEPTH);

    logic [PTR_W-1:0]      depth_q;
    logic [PTR_W-1:0]      depth_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full  = (depth_q == PTR_W'(DEPTH));
    assign empty = (depth_q == '0);

    // Guard here as well so the stack can never be corrupted by a careless
    // caller; push wins if both ever arrive together.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty & ~push;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + PTR_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage is deliberately not reset: anything above the depth
    // pointer is don't-care, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (depth_q == PTR_W'(i))) begin
                mem_q[i] <= push_data;
            end
        end
    end

    // Top of stack lives at index depth-1; a compare-select avoids an array
    // index whose width differs from the pointer width.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == PTR_W'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// SAP-2 program counter with increment, jump, and CALL/RET via a return stack.
// Latency: 1 cycle; every strobe shows on counter_out after the sampling edge.
// Backpressure: none; overflowing call / underflowing ret is dropped and sets sticky stack_err.
//
// Build option PC_STACK_EN: when defined, the return stack and call/ret are
// implemented; when undefined, call/ret act as hold, stack_empty=1,
// stack_full=0, stack_err=0, and no stack storage exists.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   enable, load, call, ret  microcode strobes (priority load>call>ret>enable)
//   load_addr              jump/call target
//   counter_out            registered PC
//   stack_empty/full/err   return-stack status (err is sticky until reset)
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = PC_ADDR_WIDTH_DEF,
    parameter int unsigned           STACK_DEPTH  = PC_STACK_DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic [ADDR_WIDTH-1:0] counter_out,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_err
);

    pc_op_e                op;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign op          = pc_resolve_op(load, call, ret, enable);
    // Natural modulo-2^ADDR_WIDTH wrap: all-ones + 1 -> 0.
    assign pc_inc      = pc_q + ADDR_WIDTH'(1);
    assign counter_out = pc_q;

`ifdef PC_STACK_EN

    logic                  st_push;
    logic                  st_pop;
    logic                  st_full;
    logic                  st_empty;
    logic [ADDR_WIDTH-1:0] st_top;
    logic                  err_q;
    logic                  err_d;

    // The return address is PC+1 with the same wrap as a plain increment.
    assign st_push = (op == PC_CALL) && !st_full;
    assign st_pop  = (op == PC_RET) && !st_empty;

    pc_return_stack #(
        .DATA_WIDTH (ADDR_WIDTH),
        .DEPTH      (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (st_push),
        .pop       (st_pop),
        .push_data (pc_inc),
        .top       (st_top),
        .full      (st_full),
        .empty     (st_empty)
    );

    // A rejected call/ret leaves the PC exactly where it was (no increment).
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        case (op)
            PC_INC:  pc_d = pc_inc;
            PC_LOAD: pc_d = load_addr;
            PC_CALL: begin
                if (st_full) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = load_addr;
                end
            end
            PC_RET: begin
                if (st_empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = st_top;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign stack_empty = st_empty;
    assign stack_full  = st_full;
    assign stack_err   = err_q;

`else

    // Without a stack, call and ret resolve to their own op and then do
    // nothing, so they still mask a simultaneous enable.
    always_comb begin
        pc_d = pc_q;
        case (op)
            PC_INC:  pc_d = pc_inc;
            PC_LOAD: pc_d = load_addr;
            default: pc_d = pc_q;
        endcase
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;

`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (ADDR_WIDTH=8, STACK_DEPTH=2).
// A queue-based reference model is checked every falling edge; literal
// expectations along the sequence pin the model to hand-worked values.
module tb_program_counter_stack;

`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic       call;
    logic       ret;
    logic [7:0] load_addr;
    logic [7:0] counter_out;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    program_counter_stack #(
        .ADDR_WIDTH   (8),
        .STACK_DEPTH  (DEPTH),
        .RESET_VECTOR (8'h00)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .load_addr   (load_addr),
        .counter_out (counter_out),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: PC value, return addresses as a queue, sticky error.
    logic [7:0] pc_m  = 8'h00;
    logic [7:0] stk_m [$];
    logic       err_m = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic l, input logic c, input logic r,
                              input logic e, input logic [7:0] a);
        if (l) begin
            pc_m = a;
        end else if (c) begin
            if (STK) begin
                if (stk_m.size() == DEPTH) begin
                    err_m = 1'b1;
                end else begin
                    stk_m.push_back(pc_m + 8'd1);
                    pc_m = a;
                end
            end
        end else if (r) begin
            if (STK) begin
                if (stk_m.size() == 0) begin
                    err_m = 1'b1;
                end else begin
                    pc_m = stk_m.pop_back();
                end
            end
        end else if (e) begin
            pc_m = pc_m + 8'd1;
        end
    endtask

    task automatic model_reset();
        pc_m  = 8'h00;
        stk_m.delete();
        err_m = 1'b0;
    endtask

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        chk("cyc_pc", counter_out, pc_m);
        chk("cyc_empty", {7'd0, stack_empty}, {7'd0, (!STK) || (stk_m.size() == 0)});
        chk("cyc_full", {7'd0, stack_full}, {7'd0, STK && (stk_m.size() == DEPTH)});
        chk("cyc_err", {7'd0, stack_err}, {7'd0, err_m});
    end

    // Drive strobes just after a falling edge, let the rising edge sample
    // them, then return just after the next falling edge.
    task automatic step(input logic l, input logic c, input logic r,
                        input logic e, input logic [7:0] a);
        load = l; call = c; ret = r; enable = e; load_addr = a;
        @(posedge clk);
        model_step(l, c, r, e, a);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        load = 1'b0; call = 1'b0; ret = 1'b0; enable = 1'b0; load_addr = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", counter_out, 8'h00);
        chk("rst_empty", {7'd0, stack_empty}, 8'h01);
        chk("rst_full", {7'd0, stack_full}, 8'h00);
        chk("rst_err", {7'd0, stack_err}, 8'h00);
        reset_n = 1'b1;

        // Plain increment, then hold.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00);
        chk("inc4_pc", counter_out, 8'h04);
        step(0, 0, 0, 0, 8'h99);
        chk("hold_pc", counter_out, 8'h04);

        // Load near the top and wrap through zero.
        step(1, 0, 0, 0, 8'hFE);
        chk("load_fe", counter_out, 8'hFE);
        step(0, 0, 0, 1, 8'h00);
        chk("wrap_ff", counter_out, 8'hFF);
        step(0, 0, 0, 1, 8'h00);
        chk("wrap_00", counter_out, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        chk("wrap_01", counter_out, 8'h01);

        // Nested calls to full, then unwind.
        step(1, 0, 0, 0, 8'h10);
        step(0, 1, 0, 0, 8'h40);
        chk("call40", counter_out, STK ? 8'h40 : 8'h10);
        step(0, 0, 0, 1, 8'h00);
        chk("inc41", counter_out, STK ? 8'h41 : 8'h11);
        step(0, 1, 0, 0, 8'h80);
        chk("call80", counter_out, STK ? 8'h80 : 8'h11);
        chk("call80_full", {7'd0, stack_full}, {7'd0, STK});
        step(0, 0, 1, 0, 8'h00);
        chk("ret42", counter_out, STK ? 8'h42 : 8'h11);
        step(0, 0, 1, 0, 8'h00);
        chk("ret11", counter_out, 8'h11);
        chk("ret11_empty", {7'd0, stack_empty}, 8'h01);

        // Overflow: dropped call, sticky error, stack still intact.
        step(0, 1, 0, 0, 8'h40);
        step(0, 1, 0, 0, 8'h50);
        step(0, 1, 0, 0, 8'h20);
        chk("ovf_pc", counter_out, STK ? 8'h50 : 8'h11);
        chk("ovf_err", {7'd0, stack_err}, {7'd0, STK});
        step(0, 0, 1, 0, 8'h00);
        chk("ovf_ret41", counter_out, STK ? 8'h41 : 8'h11);
        step(0, 0, 1, 0, 8'h00);
        chk("ovf_ret12", counter_out, STK ? 8'h12 : 8'h11);
        chk("ovf_err_sticky", {7'd0, stack_err}, {7'd0, STK});

        // Asynchronous reset between edges during a call sequence.
        step(1, 0, 0, 0, 8'h30);
        step(0, 1, 0, 0, 8'h60);
        chk("pre_rst_pc", counter_out, STK ? 8'h60 : 8'h30);
        call = 1'b1; load_addr = 8'h70;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pc", counter_out, 8'h00);
        chk("arst_empty", {7'd0, stack_empty}, 8'h01);
        chk("arst_err", {7'd0, stack_err}, 8'h00);
        @(negedge clk);
        #1;
        call = 1'b0; load_addr = 8'h00;
        reset_n = 1'b1;
        #1;
        chk("rel_pc", counter_out, 8'h00);

        // Load beats call and enable; depth must not move.
        step(0, 1, 0, 0, 8'h10);
        chk("call10", counter_out, STK ? 8'h10 : 8'h00);
        step(1, 1, 0, 1, 8'h33);
        chk("loadwins_pc", counter_out, 8'h33);
        chk("loadwins_empty", {7'd0, stack_empty}, {7'd0, !STK});
        step(0, 0, 1, 0, 8'h00);
        chk("ret01", counter_out, STK ? 8'h01 : 8'h33);

        // Back-to-back call then ret returns the just-pushed address.
        step(0, 1, 0, 0, 8'h90);
        chk("b2b_call", counter_out, STK ? 8'h90 : 8'h33);
        step(0, 0, 1, 0, 8'h00);
        chk("b2b_ret", counter_out, STK ? 8'h02 : 8'h33);

        // Underflow: PC held, error raised.
        step(0, 0, 1, 0, 8'h00);
        chk("unf_pc", counter_out, STK ? 8'h02 : 8'h33);
        chk("unf_err", {7'd0, stack_err}, {7'd0, STK});
        step(0, 0, 0, 0, 8'h00);
        chk("unf_err_hold", {7'd0, stack_err}, {7'd0, STK});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
